// File: rtl/dt_pipe_buf.sv
// In-order buffer between the TLB and cache stages; issues each entry's memory request in entry order and releases an entry once its request is accepted, with no input-to-output bypass.
// in_ready also rises when the head pops in the same cycle. Responses belonging to flushed entries are tagged on resp_discard and drained before new requests go out.
module dt_pipe_buf #(
   parameter int PAY_WD  = 275,
   parameter int TAG_WD  = 20,
   parameter int DEPTH   = 2,
   parameter int MAX_OUT = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PAY_WD-1:0] in_payload,
   input  logic              in_uncached,
   input  logic [TAG_WD-1:0] in_tag,
   input  logic [2:0]        in_exc,
   input  logic              in_mem_en,
   input  logic              in_mem_wen,
   input  logic [3:0]        in_mem_sel,
   input  logic [31:0]       in_mem_addr,
   input  logic [31:0]       in_mem_wdata,
   output logic              data_req,
   output logic              data_wr,
   output logic [3:0]        data_wstrb,
   output logic [31:0]       data_addr,
   output logic [31:0]       data_wdata,
   input  logic              data_addr_ok,
   input  logic              data_data_ok,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PAY_WD-1:0] out_payload,
   output logic              out_uncached,
   output logic [TAG_WD-1:0] out_tag,
   output logic [2:0]        out_exc,
   output logic              out_mem_req,
   output logic              resp_discard
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int OUT_W = $clog2(MAX_OUT + 1);
   localparam int DSC_W = $clog2(DEPTH + 2);

   typedef struct packed {
      logic [PAY_WD-1:0] payload;
      logic              uncached;
      logic [TAG_WD-1:0] tag;
      logic [2:0]        exc;
      logic              needs_req;
      logic              wen;
      logic [3:0]        sel;
      logic [31:0]       addr;
      logic [31:0]       wdata;
   } entry_t;

   entry_t             ent_q [DEPTH];
   logic [DEPTH-1:0]   issued_q, issued_nxt;
   logic [PTR_W-1:0]   rptr_q, wptr_q, cand_idx, slot_idx;
   logic [CNT_W-1:0]   count_q;
   logic [OUT_W-1:0]   outstanding_q, outstanding_nxt;
   logic [DSC_W-1:0]   discard_q, discard_flush;
   logic               cand_found, push, pop, issue, out_dec, disc_dec;
   int                 slot, issued_cnt, disc_sum;
   entry_t             in_ent, head, cand;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      in_ent           = '0;
      in_ent.payload   = in_payload;
      in_ent.uncached  = in_uncached;
      in_ent.tag       = in_tag;
      in_ent.exc       = in_exc;
      in_ent.needs_req = in_mem_en && (in_exc == 3'b000);
      in_ent.wen       = in_mem_wen;
      in_ent.sel       = in_mem_sel;
      in_ent.addr      = in_mem_addr;
      in_ent.wdata     = in_mem_wdata;
   end

   // Oldest buffered entry still owing a request; requests therefore leave in entry order.
   always_comb begin
      cand_found = 1'b0;
      cand_idx   = rptr_q;
      slot       = 0;
      slot_idx   = '0;
      issued_cnt = 0;
      for (int k = 0; k < DEPTH; k++) begin
         slot = int'(rptr_q) + k;
         if (slot >= DEPTH) slot = slot - DEPTH;
         slot_idx = PTR_W'(slot);
         if (!cand_found && (k < int'(count_q)) && ent_q[slot_idx].needs_req && !issued_q[slot_idx]) begin
            cand_found = 1'b1;
            cand_idx   = slot_idx;
         end
         if (issued_q[PTR_W'(k)]) issued_cnt = issued_cnt + 1;
      end
   end

   assign head = ent_q[rptr_q];
   assign cand = ent_q[cand_idx];

   assign data_req   = cand_found && (discard_q == '0) && (int'(outstanding_q) < MAX_OUT);
   assign data_wr    = cand.wen;
   assign data_wstrb = cand.sel;
   assign data_addr  = cand.addr;
   assign data_wdata = cand.wdata;

   assign out_valid    = (count_q != '0) && (issued_q[rptr_q] || !head.needs_req);
   assign out_payload  = head.payload;
   assign out_uncached = head.uncached;
   assign out_tag      = head.tag;
   assign out_exc      = head.exc;
   assign out_mem_req  = issued_q[rptr_q];

   assign pop          = out_valid && out_ready;
   assign in_ready     = (int'(count_q) < DEPTH) || pop;
   assign push         = in_valid && in_ready && !flush;
   assign issue        = data_req && data_addr_ok;
   assign resp_discard = (discard_q != '0) && (int'(outstanding_q) == int'(discard_q));
   assign out_dec      = data_data_ok && (outstanding_q != '0);
   assign disc_dec     = data_data_ok && resp_discard;

   assign outstanding_nxt = outstanding_q + OUT_W'(issue) - OUT_W'(out_dec);

   // Responses already returned for buffered entries cannot be discarded again, so clamp to what is still in flight.
   always_comb begin
      disc_sum = int'(discard_q) - int'(disc_dec) + issued_cnt + int'(issue);
      if (disc_sum > int'(outstanding_nxt)) disc_sum = int'(outstanding_nxt);
      discard_flush = DSC_W'(disc_sum);
   end

   always_comb begin
      issued_nxt = issued_q;
      if (issue) issued_nxt[cand_idx] = 1'b1;
      if (pop)   issued_nxt[rptr_q]   = 1'b0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
         issued_q      <= '0;
         rptr_q        <= '0;
         wptr_q        <= '0;
         count_q       <= '0;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         outstanding_q <= outstanding_nxt;
         if (flush) begin
            issued_q  <= '0;
            rptr_q    <= '0;
            wptr_q    <= '0;
            count_q   <= '0;
            discard_q <= discard_flush;
         end else begin
            issued_q  <= issued_nxt;
            discard_q <= discard_q - DSC_W'(disc_dec);
            count_q   <= count_q + CNT_W'(push) - CNT_W'(pop);
            if (push) begin
               ent_q[wptr_q] <= in_ent;
               wptr_q        <= ptr_inc(wptr_q);
            end
            if (pop) rptr_q <= ptr_inc(rptr_q);
         end
      end
   end

endmodule
